// File: rtl/cond_flags_unit.sv
// ============================================================================
// Module  : cond_flags_unit
// Brief   : Holds ZNCV flags, evaluates condition codes, gates write-enables.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_flags_unit #(
    parameter int          CNT_W     = 16,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [1:0]       flag_write,
    input  logic [3:0]       alu_flags,
    input  logic             reg_write_in,
    input  logic             mem_write_in,
    input  logic             pc_src_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cond_ex,
    output logic             reg_write_out,
    output logic             mem_write_out,
    output logic             pc_src_out,
    output logic             illegal_cond,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic             r_out_valid;
    logic             r_cond_ex;
    logic             r_reg_write;
    logic             r_mem_write;
    logic             r_pc_src;
    logic             r_illegal;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_squash;

    logic w_z, w_n, w_c, w_v;
    logic w_pass;
    logic w_illegal;
    logic w_accept;

    assign w_z = r_flags[3];
    assign w_n = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    always_comb begin
        w_pass    = 1'b0;
        w_illegal = 1'b0;
        case (cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = !w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = !w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = !w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = !w_v;
            4'b1000: w_pass = w_c & !w_z;
            4'b1001: w_pass = !w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = !w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            default: begin
                w_pass    = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = (!r_out_valid | out_ready) & !flush;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_cond_ex   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_pc_src    <= 1'b0;
            r_illegal   <= 1'b0;
            r_flags     <= FLAGS_RST;
            r_squash    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_cond_ex   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_pc_src    <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_cond_ex   <= w_pass;
            r_reg_write <= reg_write_in & w_pass;
            r_mem_write <= mem_write_in & w_pass;
            r_pc_src    <= pc_src_in & w_pass;
            r_illegal   <= w_illegal;
            // Flags only move for instructions that actually execute.
            if (w_pass && flag_write[1]) begin
                r_flags[3:2] <= alu_flags[3:2];
            end
            if (w_pass && flag_write[0]) begin
                r_flags[1:0] <= alu_flags[1:0];
            end
            if (!w_pass && (r_squash != C_CNT_MAX)) begin
                r_squash <= r_squash + C_CNT_ONE;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_cond_ex   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_pc_src    <= 1'b0;
            r_illegal   <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign cond_ex       = r_cond_ex;
    assign reg_write_out = r_reg_write;
    assign mem_write_out = r_mem_write;
    assign pc_src_out    = r_pc_src;
    assign illegal_cond  = r_illegal;
    assign flags_q       = r_flags;
    assign squash_cnt    = r_squash;

endmodule

`default_nettype wire

// File: tb/tb_cond_flags_unit.sv
// ============================================================================
// Module  : tb_cond_flags_unit
// Brief   : Scoreboard bench for cond_flags_unit with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_flags_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    cond;
    logic [1:0]    flag_write;
    logic [3:0]    alu_flags;
    logic          reg_write_in;
    logic          mem_write_in;
    logic          pc_src_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic          cond_ex;
    logic          reg_write_out;
    logic          mem_write_out;
    logic          pc_src_out;
    logic          illegal_cond;
    logic [3:0]    flags_q;
    logic [CW-1:0] squash_cnt;

    typedef struct packed {
        logic          pass;
        logic          rw;
        logic          mw;
        logic          ps;
        logic          ill;
        logic [3:0]    flags;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_a;
    exp_t mon_e;
    exp_t dropped;
    int   n_checks = 0;
    int   n_pass   = 0;

    cond_flags_unit #(.CNT_W(CW), .FLAGS_RST(4'b0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cond         (cond),
        .flag_write   (flag_write),
        .alu_flags    (alu_flags),
        .reg_write_in (reg_write_in),
        .mem_write_in (mem_write_in),
        .pc_src_in    (pc_src_in),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cond_ex      (cond_ex),
        .reg_write_out(reg_write_out),
        .mem_write_out(mem_write_out),
        .pc_src_out   (pc_src_out),
        .illegal_cond (illegal_cond),
        .flags_q      (flags_q),
        .squash_cnt   (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every transfer downstream is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            mon_a.pass  = cond_ex;
            mon_a.rw    = reg_write_out;
            mon_a.mw    = mem_write_out;
            mon_a.ps    = pc_src_out;
            mon_a.ill   = illegal_cond;
            mon_a.flags = flags_q;
            mon_a.cnt   = squash_cnt;
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %h expected none", mon_a);
            end else begin
                mon_e = q.pop_front();
                check("out {ex,rw,mw,ps,ill,flags,cnt}", 32'(mon_a), 32'(mon_e));
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                        input logic rw, input logic mw, input logic ps,
                        input logic ep, input logic [3:0] ef, input logic [CW-1:0] ec);
        exp_t e;
        logic ok;
        cond = c; flag_write = fw; alu_flags = af;
        reg_write_in = rw; mem_write_in = mw; pc_src_in = ps;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
        end else begin
            e.pass = ep; e.rw = rw & ep; e.mw = mw & ep; e.ps = ps & ep;
            e.ill = (c == 4'b1111); e.flags = ef; e.cnt = ec;
            q.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; cond = '0; flag_write = '0; alu_flags = '0;
        reg_write_in = 1'b0; mem_write_in = 1'b0; pc_src_in = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst cond_ex", 32'(cond_ex), 0);
        check("rst flags_q", 32'(flags_q), 0);
        check("rst squash_cnt", 32'(squash_cnt), 0);
        check("rst in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // cond, fw, alu_flags, rw, mw, ps, pass, flags_after, cnt_after
        send(4'b1110, 2'b11, 4'b1000, 1, 0, 0, 1, 4'b1000, 0);  // AL sets Z
        send(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 1, 4'b1000, 0);  // EQ pass
        send(4'b0001, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b1000, 1);  // NE fail
        send(4'b1110, 2'b11, 4'b0100, 0, 0, 0, 1, 4'b0100, 1);  // N=1 V=0
        send(4'b1100, 2'b11, 4'b0001, 0, 0, 1, 0, 4'b0100, 2);  // GT fails, no flag write
        send(4'b1110, 2'b11, 4'b1010, 0, 0, 0, 1, 4'b1010, 2);
        send(4'b1110, 2'b10, 4'b0111, 0, 0, 0, 1, 4'b0110, 2);  // Z,N only
        send(4'b1110, 2'b01, 4'b1001, 0, 0, 0, 1, 4'b0101, 2);  // C,V only
        // flags now Z=0 N=1 C=0 V=1
        send(4'b1010, 2'b00, 4'b0000, 0, 1, 0, 1, 4'b0101, 2);  // GE
        send(4'b1011, 2'b00, 4'b0000, 0, 1, 0, 0, 4'b0101, 3);  // LT
        send(4'b1000, 2'b00, 4'b0000, 1, 0, 1, 0, 4'b0101, 4);  // HI
        send(4'b1001, 2'b00, 4'b0000, 1, 0, 1, 1, 4'b0101, 4);  // LS
        send(4'b0100, 2'b00, 4'b0000, 1, 1, 1, 1, 4'b0101, 4);  // MI
        send(4'b0101, 2'b00, 4'b0000, 1, 1, 1, 0, 4'b0101, 5);  // PL
        send(4'b0110, 2'b00, 4'b0000, 0, 0, 1, 1, 4'b0101, 5);  // VS
        send(4'b0111, 2'b00, 4'b0000, 0, 0, 1, 0, 4'b0101, 6);  // VC
        send(4'b0010, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0101, 7);  // CS
        send(4'b0011, 2'b00, 4'b0000, 1, 0, 0, 1, 4'b0101, 7);  // CC
        send(4'b1101, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0101, 8);  // LE
        send(4'b1100, 2'b00, 4'b0000, 1, 0, 0, 1, 4'b0101, 8);  // GT

        // Stall: held output must not move while the next instruction waits.
        idle(2);
        out_ready = 1'b0;
        send(4'b0000, 2'b11, 4'b1111, 1, 0, 0, 0, 4'b0101, 9);
        cond = 4'b0100; flag_write = 2'b11; alu_flags = 4'b1111;
        reg_write_in = 1'b1; mem_write_in = 1'b0; pc_src_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall in_ready", 32'(in_ready), 0);
            check("stall out_valid", 32'(out_valid), 1);
            check("stall reg_write_out", 32'(reg_write_out), 0);
            check("stall flags_q", 32'(flags_q), 32'h5);
            check("stall squash_cnt", 32'(squash_cnt), 9);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'b0100, 2'b11, 4'b1111, 1, 0, 0, 1, 4'b1111, 9);

        send(4'b1111, 2'b11, 4'b0000, 1, 1, 1, 0, 4'b1111, 10);  // reserved

        // Flush with a valid input on an empty stage.
        idle(2);
        cond = 4'b1110; flag_write = 2'b11; alu_flags = 4'b0000; reg_write_in = 1'b1;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush out_valid", 32'(out_valid), 0);
        check("flush flags_q", 32'(flags_q), 32'hF);
        check("flush squash_cnt", 32'(squash_cnt), 10);

        // Flush kills a held output.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(4'b1110, 2'b00, 4'b0000, 1, 1, 0, 1, 4'b1111, 10);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        dropped = q.pop_back();
        @(negedge clk);
        check("flush_held out_valid", 32'(out_valid), 0);
        check("flush_held reg_write_out", 32'(reg_write_out), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Saturation: Z=1 so NE always fails.
        for (int i = 0; i < 7; i++) begin
            send(4'b0001, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b1111,
                 CW'((11 + i > 15) ? 15 : 11 + i));
        end

        // Reset while stalled discards the pending output.
        idle(2);
        out_ready = 1'b0;
        send(4'b1110, 2'b11, 4'b0011, 1, 0, 0, 1, 4'b0011, 15);
        @(negedge clk);
        check("prereset flags_q", 32'(flags_q), 32'h3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dropped = q.pop_back();
        @(negedge clk);
        check("midreset out_valid", 32'(out_valid), 0);
        check("midreset flags_q", 32'(flags_q), 0);
        check("midreset squash_cnt", 32'(squash_cnt), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0000, 1);

        idle(3);
        check("scoreboard drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cond_flags_unit.md
Name: cond_flags_unit

Overview:
- Consumer end of the ALU flag interface. Holds the architectural Z N C V register, updated from the ALU's flags output (bit order 3..0 = Z N C V).
- Evaluates each instruction's 4-bit condition field against the held flags.
- Gates the instruction's write-enables, squashing instructions whose condition fails.
- Sits between the execute-stage ALU and writeback, with one registered valid/ready pipeline stage.

Parameters:
- CNT_W, 16, width of the saturating squash counter
- FLAGS_RST, 4'b0000, reset value of the flag register

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- cond  in  4  condition field
- flag_write  in  2  [1]=update Z,N; [0]=update C,V
- alu_flags  in  4  ZNCV from ALU for this instruction
- reg_write_in  in  1  instruction's register write-enable
- mem_write_in  in  1  instruction's memory write-enable
- pc_src_in  in  1  instruction's branch/PC write
- flush  in  1  kill the stage contents and the current input
- out_valid  out  1  output stage valid
- out_ready  in  1  downstream accepts
- cond_ex  out  1  condition passed (registered)
- reg_write_out  out  1  reg_write_in & cond_ex (registered)
- mem_write_out  out  1  mem_write_in & cond_ex (registered)
- pc_src_out  out  1  pc_src_in & cond_ex (registered)
- illegal_cond  out  1  cond==4'b1111 for the held instruction
- flags_q  out  4  architectural ZNCV
- squash_cnt  out  CNT_W  number of accepted instructions with cond_ex=0

Behaviour:
- Reset (synchronous, dominates everything):
  - out_valid=0, cond_ex=0; all *_out=0; illegal_cond=0
  - flags_q=FLAGS_RST, squash_cnt=0
- in_ready = !out_valid | out_ready; forced 0 while flush=1.
- accept = in_valid & in_ready & !flush.
- Condition evaluation:
  - Combinational, on the current flags_q at the accept edge.
  - Encodings:
    - 0000 EQ: Z
    - 0001 NE: !Z
    - 0010 CS: C
    - 0011 CC: !C
    - 0100 MI: N
    - 0101 PL: !N
    - 0110 VS: V
    - 0111 VC: !V
    - 1000 HI: C&!Z
    - 1001 LS: !C|Z
    - 1010 GE: N==V
    - 1011 LT: N!=V
    - 1100 GT: !Z&(N==V)
    - 1101 LE: Z|(N!=V)
    - 1110 AL: 1
    - 1111 reserved: pass=0, illegal_cond=1
- On accept (single clock edge):
  - Output register loads cond_ex and the gated enables; out_valid=1.
  - If pass & flag_write[1]: flags_q[3:2] <= alu_flags[3:2].
  - If pass & flag_write[0]: flags_q[1:0] <= alu_flags[1:0].
  - Failed instructions never modify flags.
  - If !pass: squash_cnt increments, saturating at all-ones.
- Back-to-back: the instruction accepted on the next cycle evaluates against the already-updated flags_q. No bypass is needed and there are no hazard bubbles.
- No accept & out_ready & out_valid: out_valid <= 0; *_out and cond_ex clear to 0.
- Stall: out_valid & !out_ready holds all outputs stable; no accept; flags_q stable.
- Flush:
  - Next edge: out_valid=0, outputs cleared.
  - Input is not accepted; flags_q and squash_cnt unchanged.
  - Flush overrides a simultaneous valid input.
- Reset mid-stall: pending output is discarded; out_valid=0 next edge.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle while out_ready=1.

Test Plan:
- Reset, then AL + flag_write=2'b11 + alu_flags=4'b1000 -> next cycle out_valid=1, cond_ex=1, flags_q=4'b1000.
- flags_q=4'b1000, EQ with reg_write_in=1, then NE with reg_write_in=1, back-to-back -> EQ: reg_write_out=1; NE: reg_write_out=0, squash_cnt=1.
- Failed GT (flags N=1,V=0) with flag_write=2'b11, alu_flags=4'b0001 -> flags_q unchanged, pc_src_out=0.
- Partial update: flag_write=2'b10, alu_flags=4'b0111 from flags_q=4'b1010 -> flags_q=4'b0110.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, flags_q unchanged. Release -> next instruction accepted, evaluated on the original flags.
- cond=4'b1111 -> illegal_cond=1, cond_ex=0. Flush with in_valid=1 -> out_valid=0, counter/flags unchanged. Force squash_cnt to all-ones -> stays saturated.
